// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared types and constants for the intersection controller.
//  Revision    : 1.0  initial release
// ============================================================================
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GREEN  = 3'd1,
        ST_YELLOW = 3'd2,
        ST_ALLRED = 3'd3,
        ST_WALK   = 3'd4,
        ST_FLASH  = 3'd5
    } state_t;

    // Bit positions inside each direction's {red,yellow,green} lamp triple
    localparam int c_LIGHT_GREEN  = 0;
    localparam int c_LIGHT_YELLOW = 1;
    localparam int c_LIGHT_RED    = 2;

    function automatic int dir_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_intersection_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_intersection_ctrl_if
//  Description : Control/status bundle of the intersection controller.
//                TRAFFIC_PED_WALK_EN adds the ped_req / walk signals.
//  Revision    : 1.0  initial release
// ============================================================================
interface traffic_intersection_ctrl_if #(
    parameter int NUM_DIR   = 2,
    parameter int CNT_WIDTH = 8
);
    localparam int c_DIR_W = traffic_pkg::dir_width(NUM_DIR);

    logic                   en;
    logic                   tick;
    logic [3*NUM_DIR-1:0]   light;
    logic [c_DIR_W-1:0]     active_dir;
    logic [CNT_WIDTH-1:0]   remain;
`ifdef TRAFFIC_PED_WALK_EN
    logic                   ped_req;
    logic                   walk;

    modport master (
        output en, tick, ped_req,
        input  light, active_dir, remain, walk
    );
    modport slave (
        input  en, tick, ped_req,
        output light, active_dir, remain, walk
    );
`else
    modport master (
        output en, tick,
        input  light, active_dir, remain
    );
    modport slave (
        input  en, tick,
        output light, active_dir, remain
    );
`endif

endinterface
`default_nettype wire

// File: rtl/traffic_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_phase_timer
//  Description : Loadable down-counter stepped by the tick pulse; done fires
//                on a tick seen while the count is already zero.
//  Revision    : 1.0  initial release
// ============================================================================
module traffic_phase_timer #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [CNT_WIDTH-1:0] i_load_val,
    input  logic                 i_tick,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_done
);

    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_tick && (r_count != '0)) begin
            r_count <= r_count - CNT_WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_done  = i_tick && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/traffic_intersection_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_intersection_ctrl
//  Description : Round-robin signal controller with amber/all-red clearance,
//                flashing-yellow fallback and, when TRAFFIC_PED_WALK_EN is
//                defined, a pedestrian walk phase after the last direction.
//  Revision    : 1.0  initial release
// ============================================================================
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_DIR     = 2,
    parameter int CNT_WIDTH   = 8,
    parameter int GREEN_TIME  = 30,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 2,
    parameter int WALK_TIME   = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    traffic_intersection_ctrl_if.slave bus
);

    localparam int                   c_DIR_W     = dir_width(NUM_DIR);
    localparam int                   c_MAX_TIME  = 1 << CNT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] c_GREEN_LD  = CNT_WIDTH'(GREEN_TIME - 1);
    localparam logic [CNT_WIDTH-1:0] c_YELLOW_LD = CNT_WIDTH'(YELLOW_TIME - 1);
    localparam logic [CNT_WIDTH-1:0] c_ALLRED_LD = CNT_WIDTH'(ALLRED_TIME - 1);
    localparam logic [c_DIR_W-1:0]   c_LAST_DIR  = c_DIR_W'(NUM_DIR - 1);

    if ((NUM_DIR < 2) || (NUM_DIR > 8)) begin : g_chk_num_dir
        $error("traffic_intersection_ctrl: NUM_DIR must lie in 2..8");
    end
    if ((GREEN_TIME  < 1) || (GREEN_TIME  > c_MAX_TIME) ||
        (YELLOW_TIME < 1) || (YELLOW_TIME > c_MAX_TIME) ||
        (ALLRED_TIME < 1) || (ALLRED_TIME > c_MAX_TIME) ||
        (WALK_TIME   < 1) || (WALK_TIME   > c_MAX_TIME)) begin : g_chk_times
        $error("traffic_intersection_ctrl: phase durations must lie in 1..2^CNT_WIDTH");
    end

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_DIR_W-1:0]     r_dir;
    logic [c_DIR_W-1:0]     w_dir_nxt;
    logic                   r_flash_yel;
    logic                   w_flash_yel_nxt;
    logic                   w_load;
    logic [CNT_WIDTH-1:0]   w_load_val;
    logic [CNT_WIDTH-1:0]   w_count;
    logic                   w_done;
    logic [3*NUM_DIR-1:0]   r_light;
    logic [3*NUM_DIR-1:0]   w_light_nxt;
    logic                   w_lamp_green;
    logic                   w_lamp_yellow;
    logic                   w_red_others;
    logic                   w_red_all;
    logic                   w_flash_on;

    traffic_phase_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_tick     (bus.tick),
        .o_count    (w_count),
        .o_done     (w_done)
    );

    // ------------------------------------------------------------------
    // State register; all outputs are registered alongside it
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_dir       <= '0;
            r_flash_yel <= 1'b0;
            r_light     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_dir       <= w_dir_nxt;
            r_flash_yel <= w_flash_yel_nxt;
            r_light     <= w_light_nxt;
        end
    end

`ifdef TRAFFIC_PED_WALK_EN
    logic r_pending;
    logic w_pending_nxt;
    logic r_walk;
    logic w_walk_nxt;
    localparam logic [CNT_WIDTH-1:0] c_WALK_LD = CNT_WIDTH'(WALK_TIME - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_walk    <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_walk    <= w_walk_nxt;
        end
    end

    // Entering WALK or FLASH wins over a same-cycle request
    always_comb begin
        w_pending_nxt = r_pending;
        if ((r_state != ST_IDLE) && (r_state != ST_FLASH) && bus.ped_req) begin
            w_pending_nxt = 1'b1;
        end
        if ((w_state_nxt == ST_FLASH) ||
            ((w_state_nxt == ST_WALK) && (r_state != ST_WALK))) begin
            w_pending_nxt = 1'b0;
        end
    end

    assign bus.walk = r_walk;
`endif

    // ------------------------------------------------------------------
    // Next-state logic; a low enable outranks any phase timeout
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_dir_nxt       = r_dir;
        w_flash_yel_nxt = r_flash_yel;
        w_load          = 1'b0;
        w_load_val      = '0;
        if (r_state == ST_IDLE) begin
            if (bus.en) begin
                w_state_nxt = ST_GREEN;
                w_dir_nxt   = '0;
                w_load      = 1'b1;
                w_load_val  = c_GREEN_LD;
            end
        end else if (!bus.en) begin
            if (r_state != ST_FLASH) begin
                w_state_nxt     = ST_FLASH;
                w_flash_yel_nxt = 1'b1;
                w_load          = 1'b1;
                w_load_val      = '0;
            end else if (bus.tick) begin
                w_flash_yel_nxt = !r_flash_yel;
            end
        end else begin
            case (r_state)
                ST_FLASH: begin
                    w_state_nxt     = ST_ALLRED;
                    w_dir_nxt       = c_LAST_DIR;
                    w_flash_yel_nxt = 1'b0;
                    w_load          = 1'b1;
                    w_load_val      = c_ALLRED_LD;
                end
                ST_GREEN: begin
                    if (w_done) begin
                        w_state_nxt = ST_YELLOW;
                        w_load      = 1'b1;
                        w_load_val  = c_YELLOW_LD;
                    end
                end
                ST_YELLOW: begin
                    if (w_done) begin
                        w_state_nxt = ST_ALLRED;
                        w_load      = 1'b1;
                        w_load_val  = c_ALLRED_LD;
                    end
                end
                ST_ALLRED: begin
                    if (w_done) begin
`ifdef TRAFFIC_PED_WALK_EN
                        if (r_pending && (r_dir == c_LAST_DIR)) begin
                            w_state_nxt = ST_WALK;
                            w_load      = 1'b1;
                            w_load_val  = c_WALK_LD;
                        end else
`endif
                        begin
                            w_state_nxt = ST_GREEN;
                            w_dir_nxt   = (r_dir == c_LAST_DIR) ? '0 : r_dir + c_DIR_W'(1);
                            w_load      = 1'b1;
                            w_load_val  = c_GREEN_LD;
                        end
                    end
                end
`ifdef TRAFFIC_PED_WALK_EN
                ST_WALK: begin
                    if (w_done) begin
                        w_state_nxt = ST_GREEN;
                        w_dir_nxt   = '0;
                        w_load      = 1'b1;
                        w_load_val  = c_GREEN_LD;
                    end
                end
`endif
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_dir_nxt   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the upcoming state so lamps move with the state
    // ------------------------------------------------------------------
    always_comb begin
        w_lamp_green  = (w_state_nxt == ST_GREEN);
        w_lamp_yellow = (w_state_nxt == ST_YELLOW);
        w_red_others  = (w_state_nxt == ST_GREEN) || (w_state_nxt == ST_YELLOW);
        w_red_all     = (w_state_nxt == ST_ALLRED) || (w_state_nxt == ST_WALK);
        w_flash_on    = (w_state_nxt == ST_FLASH) && w_flash_yel_nxt;
`ifdef TRAFFIC_PED_WALK_EN
        w_walk_nxt    = (w_state_nxt == ST_WALK);
`endif
    end

    for (genvar d = 0; d < NUM_DIR; d++) begin : g_light
        logic w_is_active;
        assign w_is_active = (w_dir_nxt == c_DIR_W'(d));
        assign w_light_nxt[3*d + c_LIGHT_GREEN]  = w_lamp_green && w_is_active;
        assign w_light_nxt[3*d + c_LIGHT_YELLOW] = (w_lamp_yellow && w_is_active) || w_flash_on;
        assign w_light_nxt[3*d + c_LIGHT_RED]    = w_red_all || (w_red_others && !w_is_active);
    end

    assign bus.light      = r_light;
    assign bus.active_dir = r_dir;
    assign bus.remain     = w_count;

endmodule
`default_nettype wire
